// File: rtl/flit_pkg.sv
// Shared flit/packet types, FSM state encoding and packet helpers for the flit packetizer.
// Packet layout: head, body_1..body_4, tail; flit index 0 is head, index 5 is tail.
package flit_pkg;

  localparam int FLIT_WIDTH = 16;
  localparam int PKT_FLITS  = 6;
  localparam int IDX_W      = 3;

  localparam logic [IDX_W-1:0] HEAD_IDX = 3'd0;
  localparam logic [IDX_W-1:0] TAIL_IDX = 3'd5;

  typedef logic [FLIT_WIDTH-1:0] flit_t;

  // body[0] carries body_1, body[3] carries body_4
  typedef struct packed {
    flit_t       head;
    flit_t [3:0] body;
    flit_t       tail;
  } pkt_t;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic flit_t pkt_checksum(input pkt_t p);
    return p.head ^ p.body[0] ^ p.body[1] ^ p.body[2] ^ p.body[3];
  endfunction

  function automatic flit_t pkt_flit(input pkt_t p, input logic [IDX_W-1:0] idx);
    flit_t f;
    case (idx)
      3'd0:    f = p.head;
      3'd1:    f = p.body[0];
      3'd2:    f = p.body[1];
      3'd3:    f = p.body[2];
      3'd4:    f = p.body[3];
      3'd5:    f = p.tail;
      default: f = '0;
    endcase
    return f;
  endfunction

  function automatic flit_type_e idx_type(input logic [IDX_W-1:0] idx);
    flit_type_e t;
    case (idx)
      3'd0:                   t = FT_HEAD;
      3'd1, 3'd2, 3'd3, 3'd4: t = FT_BODY;
      3'd5:                   t = FT_TAIL;
      default:                t = FT_IDLE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/flit_pkt_slot.sv
// Six-flit packet register bank with load enable; one-cycle load, no flow control of its own.
// With FLIT_PACKETIZER_CHECKSUM_EN the stored tail is the XOR of head and the four body flits.
module flit_pkt_slot
  import flit_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  pkt_t pkt_d,
  output pkt_t pkt_q
);

  pkt_t pkt_store;

  always_comb begin
    pkt_store = pkt_d;
`ifdef FLIT_PACKETIZER_CHECKSUM_EN
    pkt_store.tail = pkt_checksum(pkt_d);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else if (load) begin
      pkt_q <= pkt_store;
    end
  end

endmodule

// File: rtl/flit_packetizer.sv
// Serialises a parallel six-flit packet into flits; head valid the cycle after accept.
// Flit output holds under i_flit_ready low; o_ready drops only while the pending slot is full.
// Optional FLIT_PACKETIZER_CHECKSUM_EN replaces the tail with an XOR checksum.
module flit_packetizer
  import flit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [FLIT_WIDTH-1:0] i_head_flit,
  input  logic [FLIT_WIDTH-1:0] i_body_flit_1,
  input  logic [FLIT_WIDTH-1:0] i_body_flit_2,
  input  logic [FLIT_WIDTH-1:0] i_body_flit_3,
  input  logic [FLIT_WIDTH-1:0] i_body_flit_4,
  input  logic [FLIT_WIDTH-1:0] i_tail_flit,
  output logic [FLIT_WIDTH-1:0] o_flit,
  output logic                  o_flit_valid,
  input  logic                  i_flit_ready,
  output logic [1:0]            o_flit_type,
  output logic                  o_busy
);

  state_e           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             pend_valid;

  logic accept, xfer, tail_done;
  logic act_load, act_from_pend, pend_load, pend_clr;

  pkt_t in_pkt, act_d, act_q, pend_q;

  assign in_pkt.head    = i_head_flit;
  assign in_pkt.body[0] = i_body_flit_1;
  assign in_pkt.body[1] = i_body_flit_2;
  assign in_pkt.body[2] = i_body_flit_3;
  assign in_pkt.body[3] = i_body_flit_4;
  assign in_pkt.tail    = i_tail_flit;

  // o_ready comes straight from a flop so upstream sees no path from i_valid
  assign o_ready   = !pend_valid;
  assign accept    = i_valid && o_ready;
  assign xfer      = o_flit_valid && i_flit_ready;
  assign tail_done = xfer && (idx == TAIL_IDX);

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    pend_clr      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          act_load = 1'b1;
          idx_n    = HEAD_IDX;
          state_n  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tail_done) begin
          idx_n = HEAD_IDX;
          if (pend_valid) begin
            act_load      = 1'b1;
            act_from_pend = 1'b1;
            pend_clr      = 1'b1;
          end else if (accept) begin
            act_load = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            idx_n = idx + 3'd1;
          end
          pend_load = accept;
        end
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = HEAD_IDX;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= HEAD_IDX;
      pend_valid <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (pend_load) begin
        pend_valid <= 1'b1;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Pending already holds its final tail, so re-deriving the checksum on copy is harmless
  assign act_d = act_from_pend ? pend_q : in_pkt;

  flit_pkt_slot u_active (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (act_load),
    .pkt_d (act_d),
    .pkt_q (act_q)
  );

  flit_pkt_slot u_pending (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pend_load),
    .pkt_d (in_pkt),
    .pkt_q (pend_q)
  );

  always_comb begin
    o_flit_valid = (state == ST_SEND);
    o_busy       = (state == ST_SEND) || pend_valid;
    o_flit       = '0;
    o_flit_type  = FT_IDLE;
    if (state == ST_SEND) begin
      o_flit      = pkt_flit(act_q, idx);
      o_flit_type = idx_type(idx);
    end
  end

endmodule
